// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared opcodes, sequencer state encoding and control-word bit indices.
package cpu_ctrl_pkg;

    localparam logic [7:0] OP_STORE = 8'h01;
    localparam logic [7:0] OP_LOAD  = 8'h02;
    localparam logic [7:0] OP_ADD   = 8'h03;
    localparam logic [7:0] OP_SUB   = 8'h04;
    localparam logic [7:0] OP_JGEZ  = 8'h05;
    localparam logic [7:0] OP_JMP   = 8'h06;
    localparam logic [7:0] OP_HALT  = 8'h07;
    localparam logic [7:0] OP_MPY   = 8'h08;
    localparam logic [7:0] OP_DIV   = 8'h09;
    localparam logic [7:0] OP_AND   = 8'h0A;
    localparam logic [7:0] OP_OR    = 8'h0B;
    localparam logic [7:0] OP_NOT   = 8'h0C;
    localparam logic [7:0] OP_SHL   = 8'h0D;
    localparam logic [7:0] OP_SHR   = 8'h0E;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FA,
        S_FM,
        S_FI,
        S_DECODE,
        S_EM,
        S_EB,
        S_EX,
        S_S1,
        S_S2,
        S_HALTED,
        S_FAULT
    } state_t;

    localparam int C0  = 0;
    localparam int C1  = 1;
    localparam int C2  = 2;
    localparam int C3  = 3;
    localparam int C4  = 4;
    localparam int C5  = 5;
    localparam int C6  = 6;
    localparam int C7  = 7;
    localparam int C8  = 8;
    localparam int C9  = 9;
    localparam int C10 = 10;
    localparam int C13 = 13;
    localparam int C15 = 15;
    localparam int C16 = 16;
    localparam int C17 = 17;
    localparam int C18 = 18;
    localparam int C19 = 19;
    localparam int C20 = 20;
    localparam int C21 = 21;

endpackage

// File: rtl/cpu_op_decode.sv
// cpu_op_decode: combinational opcode classifier.
//   ir_opcode   : IR[15:8]
//   alu_bit_idx : control-word bit asserted in EX (LOAD passes through the adder)
//   is_mem_op   : opcode addresses memory (drives MAR<-IR[7:0] in DECODE), includes STORE
//   is_store, is_jmp, is_jgez, is_halt : single-opcode flags
module cpu_op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [7:0] ir_opcode,
    output logic [4:0] alu_bit_idx,
    output logic       is_mem_op,
    output logic       is_store,
    output logic       is_jmp,
    output logic       is_jgez,
    output logic       is_halt
);

    always_comb begin
        alu_bit_idx = '0;
        is_mem_op   = 1'b1;
        is_store    = ir_opcode == OP_STORE;
        is_jmp      = ir_opcode == OP_JMP;
        is_jgez     = ir_opcode == OP_JGEZ;
        is_halt     = ir_opcode == OP_HALT;
        case (ir_opcode)
            OP_STORE:        alu_bit_idx = '0;
            OP_LOAD, OP_ADD: alu_bit_idx = 5'(C9);
            OP_SUB:          alu_bit_idx = 5'(C13);
            OP_MPY:          alu_bit_idx = 5'(C15);
            OP_DIV:          alu_bit_idx = 5'(C16);
            OP_SHL:          alu_bit_idx = 5'(C17);
            OP_SHR:          alu_bit_idx = 5'(C18);
            OP_AND:          alu_bit_idx = 5'(C19);
            OP_OR:           alu_bit_idx = 5'(C20);
            OP_NOT:          alu_bit_idx = 5'(C21);
            default:         is_mem_op   = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: microprogrammed fetch/decode/execute sequencer driving the one-hot control word.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : leaves IDLE (ignored elsewhere)
//   ir_opcode    : IR[15:8], valid from the cycle after IR<-MBR
//   alu_flags    : {ZF, CF, OF, SF}; only SF is used (JGEZ)
//   mem_ready    : memory access complete
//   C            : control word, combinational from state/opcode/flags
//   busy, halted, fault : status
//   instr_count  : DECODE cycles seen, wrapping
module cpu_ctrl_seq
    import cpu_ctrl_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  ir_opcode,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic [21:0] C,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] instr_count
);

    localparam int CW = $clog2(WAIT_TIMEOUT + 1);

    state_t        state, state_n;
    logic [CW-1:0] wait_cnt;
    logic [4:0]    alu_bit_idx;
    logic          is_mem_op, is_store, is_jmp, is_jgez, is_halt;
    logic          in_wait, timeout;
    logic          unused_flags;

    assign unused_flags = ^alu_flags[3:1];

    cpu_op_decode u_dec (
        .ir_opcode  (ir_opcode),
        .alu_bit_idx(alu_bit_idx),
        .is_mem_op  (is_mem_op),
        .is_store   (is_store),
        .is_jmp     (is_jmp),
        .is_jgez    (is_jgez),
        .is_halt    (is_halt)
    );

    assign in_wait = state inside {S_FM, S_EM, S_S2};
    // This cycle's miss would bring the wait count to WAIT_TIMEOUT.
    assign timeout = !mem_ready && wait_cnt == CW'(WAIT_TIMEOUT - 1);

    assign busy   = !(state inside {S_IDLE, S_HALTED, S_FAULT});
    assign halted = state == S_HALTED;
    assign fault  = state == S_FAULT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            state       <= state_n;
            // Cleared on every state change, so each wait state starts from zero.
            wait_cnt    <= (state_n != state) ? '0 : (in_wait && !mem_ready) ? wait_cnt + 1'b1 : wait_cnt;
            instr_count <= (state == S_DECODE) ? instr_count + 1'b1 : instr_count;
        end
    end

    always_comb begin
        state_n = state;
        C       = '0;
        case (state)
            S_IDLE:   state_n = start ? S_FA : S_IDLE;
            S_FA: begin
                C[C0]   = 1'b1;
                state_n = S_FM;
            end
            S_FM: begin
                C[C1]   = 1'b1;
                state_n = mem_ready ? S_FI : timeout ? S_FAULT : S_FM;
            end
            S_FI: begin
                C[C2]   = 1'b1;
                C[C3]   = 1'b1;
                state_n = S_DECODE;
            end
            S_DECODE: begin
                C[C4]   = is_mem_op;
                C[C10]  = is_jmp || (is_jgez && !alu_flags[0]);
                state_n = is_halt ? S_HALTED : is_store ? S_S1 : is_mem_op ? S_EM : S_FA;
            end
            S_EM: begin
                C[C1]   = 1'b1;
                state_n = mem_ready ? S_EB : timeout ? S_FAULT : S_EM;
            end
            S_EB: begin
                C[C5]   = 1'b1;
                C[C8]   = ir_opcode == OP_LOAD;
                state_n = S_EX;
            end
            S_EX: begin
                C[alu_bit_idx] = 1'b1;
                state_n        = S_FA;
            end
            S_S1: begin
                C[C6]   = 1'b1;
                state_n = S_S2;
            end
            S_S2: begin
                C[C7]   = 1'b1;
                state_n = mem_ready ? S_FA : timeout ? S_FAULT : S_S2;
            end
            default:  state_n = state;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: directed plus random instruction streams checked against a per-instruction control-word model.
module tb_cpu_ctrl_seq;

    localparam int WT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic [7:0]  ir_opcode = 8'h00;
    logic [3:0]  alu_flags = 4'h0;
    logic [21:0] C;
    logic        busy, halted, fault;
    logic [15:0] instr_count;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_count = 16'h0;

    typedef struct {
        logic [21:0] c;
        logic        mr;
    } step_t;
    step_t q[$];

    always #5 clk = ~clk;

    cpu_ctrl_seq #(.WAIT_TIMEOUT(WT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ir_opcode  (ir_opcode),
        .alu_flags  (alu_flags),
        .mem_ready  (mem_ready),
        .C          (C),
        .busy       (busy),
        .halted     (halted),
        .fault      (fault),
        .instr_count(instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] b(input int i);
        return 22'(1) << i;
    endfunction

    // ALU control bit that an opcode fires in EX; -1 for opcodes with no EX phase.
    function automatic int op_bit(input logic [7:0] op);
        case (op)
            8'h02, 8'h03: return 9;
            8'h04:        return 13;
            8'h08:        return 15;
            8'h09:        return 16;
            8'h0A:        return 19;
            8'h0B:        return 20;
            8'h0C:        return 21;
            8'h0D:        return 17;
            8'h0E:        return 18;
            default:      return -1;
        endcase
    endfunction

    task automatic wait_stage(input logic [21:0] c, input int w);
        for (int k = 0; k < w; k++) q.push_back('{c: c, mr: 1'b0});
        q.push_back('{c: c, mr: 1'b1});
    endtask

    // Expected per-cycle control words for one instruction, starting at FA.
    task automatic build(input logic [7:0] op, input logic sf, input int wfm, input int wem, input int ws2);
        logic [21:0] dec;
        q.delete();
        q.push_back('{c: b(0), mr: 1'b0});
        wait_stage(b(1), wfm);
        q.push_back('{c: b(2) | b(3), mr: 1'b0});
        dec = '0;
        if (op_bit(op) >= 0 || op == 8'h01) dec = b(4);
        if (op == 8'h06 || (op == 8'h05 && !sf)) dec = b(10);
        q.push_back('{c: dec, mr: 1'b0});
        if (op_bit(op) >= 0) begin
            wait_stage(b(1), wem);
            q.push_back('{c: b(5) | (op == 8'h02 ? b(8) : 22'h0), mr: 1'b0});
            q.push_back('{c: b(op_bit(op)), mr: 1'b0});
        end else if (op == 8'h01) begin
            q.push_back('{c: b(6), mr: 1'b0});
            wait_stage(b(7), ws2);
        end
    endtask

    // Entered #1 after the edge that begins FA; leaves #1 after the edge that ends the instruction.
    task automatic run_instr(input logic [7:0] op, input logic sf, input int wfm, input int wem, input int ws2);
        build(op, sf, wfm, wem, ws2);
        for (int i = 0; i < q.size(); i++) begin
            mem_ready = q[i].mr;
            if (i == 3) begin
                ir_opcode = op;
                alu_flags = {3'($urandom), sf};
            end
            @(negedge clk);
            chk($sformatf("ctrl op%02h step%0d", op, i), 32'(C), 32'(q[i].c));
            chk($sformatf("busy op%02h step%0d", op, i), 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            if (i == 3) exp_count = exp_count + 16'd1;
        end
        mem_ready = 1'b0;
        chk($sformatf("instr_count op%02h", op), 32'(instr_count), 32'(exp_count));
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1;
        start = 1'b1;
        @(negedge clk);
        chk("idle ctrl", 32'(C), 32'd0);
        chk("idle busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] op;
        int         v;
        #12;
        chk("rst ctrl", 32'(C), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst fault", 32'(fault), 32'd0);
        chk("rst instr_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();

        run_instr(8'h02, 1'b0, 0, 0, 0);
        run_instr(8'h03, 1'b0, 0, 3, 0);
        run_instr(8'h05, 1'b1, 0, 0, 0);
        run_instr(8'h05, 1'b0, 0, 0, 0);
        run_instr(8'h01, 1'b0, 1, 0, 2);
        run_instr(8'h06, 1'b0, 2, 0, 0);
        run_instr(8'h55, 1'b0, 0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            v = int'($urandom_range(0, 15));
            op = (v == 7) ? 8'h0F : (v == 15) ? (8'h80 | 8'($urandom)) : 8'(v);
            run_instr(op, 1'($urandom), int'($urandom_range(0, WT - 1)),
                      int'($urandom_range(0, WT - 1)), int'($urandom_range(0, WT - 1)));
        end

        run_instr(8'h07, 1'b0, 1, 0, 0);
        @(negedge clk);
        chk("halt halted", 32'(halted), 32'd1);
        chk("halt busy", 32'(busy), 32'd0);
        chk("halt ctrl", 32'(C), 32'd0);
        pulse_start();
        @(negedge clk);
        chk("halt after start", 32'(halted), 32'd1);
        chk("halt ctrl after start", 32'(C), 32'd0);

        rst_n = 1'b0;
        exp_count = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        run_instr(8'h02, 1'b0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("mid FM ctrl", 32'(C), 32'(b(1)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst ctrl", 32'(C), 32'd0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst instr_count", 32'(instr_count), 32'd0);
        exp_count = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;

        pulse_start();
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < WT; k++) begin
            @(negedge clk);
            chk($sformatf("stuck FM ctrl %0d", k), 32'(C), 32'(b(1)));
            chk($sformatf("stuck FM fault %0d", k), 32'(fault), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("timeout fault", 32'(fault), 32'd1);
        chk("timeout ctrl", 32'(C), 32'd0);
        chk("timeout busy", 32'(busy), 32'd0);
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("fault terminal", 32'(fault), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
